// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and pending-write scoreboard for the integer register file.
// Two requesters (ALU = A, LSU = B) share the single register-file write port
// under round-robin priority; the scoreboard tracks destination registers that
// were reserved at issue and have not yet been written back.
module rf_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [AW-1:0]   a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [AW-1:0]   b_rd,
    input  logic [XLEN-1:0] b_data,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_rd,
    input  logic [AW-1:0]   chk_rs1,
    input  logic [AW-1:0]   chk_rs2,
    output logic            busy_rs1,
    output logic            busy_rs2,
    output logic            stall,
    output logic            wb_wren,
    output logic [AW-1:0]   wb_rd_addr,
    output logic [XLEN-1:0] wb_data,
    output logic [NREG-1:0] pending
);

    // prio: 0 = A favoured, 1 = B favoured
    logic            prio;
    logic            hs_p0;
    logic [AW-1:0]   win_rd_p0;
    logic [XLEN-1:0] win_data_p0;
    logic            vld_p1;
    logic [AW-1:0]   rd_p1;
    logic [XLEN-1:0] data_p1;
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_nxt;

    // Grant: an uncontested request always wins, contention resolved by prio.
    always_comb begin
        a_ready     = a_valid & (~b_valid | ~prio);
        b_ready     = b_valid & (~a_valid | prio);
        hs_p0       = a_ready | b_ready;
        win_rd_p0   = a_ready ? a_rd   : b_rd;
        win_data_p0 = a_ready ? a_data : b_data;
    end

    // Priority flips to the requester that was not served on every handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (a_ready) begin
            prio <= 1'b1;
        end else if (b_ready) begin
            prio <= 1'b0;
        end
    end

    // ---- stage p0 -> p1: register the winning write onto the port ----
    // Writes to x0 consume the grant but never raise the write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            rd_p1   <= '0;
            data_p1 <= '0;
        end else if (hs_p0) begin
            vld_p1  <= (win_rd_p0 != '0);
            rd_p1   <= win_rd_p0;
            data_p1 <= win_data_p0;
        end else begin
            vld_p1  <= 1'b0;
        end
    end

    // Scoreboard next state: clear on write-back, then set on reservation so a
    // new producer of the same register supersedes the one completing now.
    always_comb begin
        pend_nxt = pend_q;
        if (vld_p1) begin
            pend_nxt[rd_p1] = 1'b0;
        end
        if (rsv_en && (rsv_rd != '0)) begin
            pend_nxt[rsv_rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // Scoreboard register; all reservations are lost on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_nxt;
        end
    end

    // Hazard lookups and port outputs.
    always_comb begin
        busy_rs1   = pend_q[chk_rs1];
        busy_rs2   = pend_q[chk_rs2];
        stall      = busy_rs1 | busy_rs2;
        wb_wren    = vld_p1;
        wb_rd_addr = rd_p1;
        wb_data    = data_p1;
        pending    = pend_q;
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed scenarios with literal expectations
// plus a long randomized run compared every cycle against a behavioural model.
module tb_rf_wb_arbiter;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            a_valid, b_valid, rsv_en;
    logic            a_ready, b_ready;
    logic [4:0]      a_rd, b_rd, rsv_rd, chk_rs1, chk_rs2;
    logic [XLEN-1:0] a_data, b_data;
    logic            busy_rs1, busy_rs2, stall, wb_wren;
    logic [4:0]      wb_rd_addr;
    logic [XLEN-1:0] wb_data;
    logic [NREG-1:0] pending;

    int total = 0;
    int bad   = 0;

    rf_wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .rsv_en(rsv_en), .rsv_rd(rsv_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
        .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .stall(stall),
        .wb_wren(wb_wren), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_last_b: the last served requester was B (or nothing since reset),
    // so A is the one to serve next under contention.
    bit            m_last_b;
    bit            m_pend [NREG];
    bit            m_wren;
    logic [4:0]    m_addr;
    logic [XLEN-1:0] m_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last_b = 1'b1;
            m_wren   = 1'b0;
            m_addr   = '0;
            m_data   = '0;
            for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
        end else begin
            bit win_a, win_b;
            win_a = a_valid && (!b_valid || m_last_b);
            win_b = b_valid && !win_a;
            if (m_wren) m_pend[m_addr] = 1'b0;
            if (rsv_en && rsv_rd != 0) m_pend[rsv_rd] = 1'b1;
            if (win_a || win_b) begin
                m_addr   = win_a ? a_rd : b_rd;
                m_data   = win_a ? a_data : b_data;
                m_wren   = (m_addr != 0);
                m_last_b = win_b;
            end else begin
                m_wren = 1'b0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [NREG-1:0] pv;
        bit ea, eb;
        ea = a_valid && (!b_valid || m_last_b);
        eb = b_valid && !ea;
        for (int i = 0; i < NREG; i++) pv[i] = m_pend[i];
        chk("a_ready",  a_ready,  ea);
        chk("b_ready",  b_ready,  eb);
        chk("busy_rs1", busy_rs1, m_pend[chk_rs1]);
        chk("busy_rs2", busy_rs2, m_pend[chk_rs2]);
        chk("stall",    stall,    m_pend[chk_rs1] | m_pend[chk_rs2]);
        chk("wb_wren",  wb_wren,  m_wren);
        chk("pending",  pending,  pv);
        if (m_wren) begin
            chk("wb_rd_addr", wb_rd_addr, m_addr);
            chk("wb_data",    wb_data,    m_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic idle();
        a_valid = 0; b_valid = 0; rsv_en = 0;
    endtask

    initial begin
        bit a_hs, b_hs;
        rst_n = 0;
        a_valid = 0; b_valid = 0; rsv_en = 0;
        a_rd = 0; b_rd = 0; a_data = 0; b_data = 0;
        rsv_rd = 0; chk_rs1 = 0; chk_rs2 = 0;

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            tick();
            a_valid = 1'($urandom); b_valid = 1'($urandom); rsv_en = 1'($urandom);
            a_rd = 5'($urandom); b_rd = 5'($urandom); rsv_rd = 5'($urandom);
            a_data = $urandom; b_data = $urandom;
            chk_rs1 = 5'($urandom); chk_rs2 = 5'($urandom);
            mid();
            chk("rst_wren", wb_wren, 0);
            chk("rst_pending", pending, 0);
            chk("rst_stall", stall, 0);
        end

        // Release with contention: A, B, A, B.
        tick();
        rst_n = 1; rsv_en = 0; chk_rs1 = 0; chk_rs2 = 0;
        a_valid = 1; a_rd = 5; a_data = 32'h11;
        b_valid = 1; b_rd = 6; b_data = 32'h22;
        mid();
        chk("g0_a", a_ready, 1); chk("g0_b", b_ready, 0);
        tick(); mid();
        chk("g1_b", b_ready, 1); chk("g1_a", a_ready, 0);
        chk("w0_en", wb_wren, 1); chk("w0_addr", wb_rd_addr, 5); chk("w0_data", wb_data, 32'h11);
        tick(); mid();
        chk("g2_a", a_ready, 1);
        chk("w1_addr", wb_rd_addr, 6); chk("w1_data", wb_data, 32'h22);
        tick(); mid();
        chk("g3_b", b_ready, 1);
        chk("w2_addr", wb_rd_addr, 5);
        tick(); idle(); mid();
        chk("w3_en", wb_wren, 1); chk("w3_addr", wb_rd_addr, 6); chk("w3_data", wb_data, 32'h22);
        tick(); mid();
        chk("idle_wren", wb_wren, 0); chk("idle_addr_hold", wb_rd_addr, 6);

        // Write to x0: granted, no write enable.
        tick();
        a_valid = 1; a_rd = 0; a_data = 32'hDEAD;
        mid();
        chk("x0_ready", a_ready, 1);
        tick(); idle(); mid();
        chk("x0_wren", wb_wren, 0);
        chk("x0_data", wb_data, 32'hDEAD);
        chk("x0_pend", pending, 0);

        // RAW hazard on x7: reserve in cycle 0, write handshake in cycle 3.
        tick();
        rsv_en = 1; rsv_rd = 7; chk_rs1 = 7; chk_rs2 = 0;
        mid(); chk("hz_c0", busy_rs1, 0);
        tick(); rsv_en = 0;
        mid(); chk("hz_c1", busy_rs1, 1); chk("hz_c1_stall", stall, 1);
        tick(); mid(); chk("hz_c2", busy_rs1, 1);
        tick(); a_valid = 1; a_rd = 7; a_data = 32'h77;
        mid(); chk("hz_c3", busy_rs1, 1); chk("hz_c3_rdy", a_ready, 1);
        tick(); idle();
        mid(); chk("hz_c4", busy_rs1, 1); chk("hz_c4_wren", wb_wren, 1);
        tick(); mid(); chk("hz_c5", busy_rs1, 0); chk("hz_c5_stall", stall, 0);

        // Set/clear collision on x9.
        tick(); rsv_en = 1; rsv_rd = 9; chk_rs2 = 9;
        tick(); rsv_en = 0; b_valid = 1; b_rd = 9; b_data = 32'h99;
        tick(); b_valid = 0; rsv_en = 1; rsv_rd = 9;
        mid(); chk("col_wren", wb_wren, 1); chk("col_addr", wb_rd_addr, 9);
        tick(); idle();
        mid(); chk("col_pend9", pending[9], 1); chk("col_busy", busy_rs2, 1);

        // Mid-operation reset drops the in-flight write and all reservations.
        tick(); a_valid = 1; a_rd = 10; a_data = 32'hAA; rsv_en = 1; rsv_rd = 12;
        mid(); chk("mr_rdy", a_ready, 1);
        tick(); idle();
        mid(); chk("mr_wren", wb_wren, 1); chk("mr_pend12", pending[12], 1);
        rst_n = 0; #1;
        chk("mr_wren_rst", wb_wren, 0); chk("mr_pend_rst", pending, 0);
        tick(); rst_n = 1;

        // Randomized traffic; requesters hold their request until granted.
        a_hs = 0; b_hs = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!a_valid || a_hs) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_rd = 5'($urandom_range(0, 15)); a_data = $urandom;
            end
            if (!b_valid || b_hs) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_rd = 5'($urandom_range(0, 15)); b_data = $urandom;
            end
            rsv_en = 1'($urandom); rsv_rd = 5'($urandom_range(0, 15));
            chk_rs1 = 5'($urandom_range(0, 15)); chk_rs2 = 5'($urandom_range(0, 15));
            mid();
            a_hs = a_ready; b_hs = b_ready;
        end

        tick(); idle();
        mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
